// File: rtl/encoder_selector_seq_pkg.sv
// Shared constants and types for the sequential encoder length selector.
//   FREQ_BIT / ENCODER_NUM_BIT / TOTAL_LEN_BIT : default field widths
//   DEF_LEN_TABLE : codeword lengths, entry (e,s) at [(e*NUM_SYM+s)*LEN_W +: LEN_W]
//   state_t       : selector FSM state encoding
package encoder_selector_seq_pkg;

    localparam int FREQ_BIT        = 10;
    localparam int ENCODER_NUM_BIT = 2;
    localparam int TOTAL_LEN_BIT   = 16;
    localparam int DEF_NUM_SYM     = 5;
    localparam int DEF_NUM_ENC     = 3;
    localparam int DEF_LEN_W       = 3;

    // Written MSB first: enc2 s4..s0, enc1 s4..s0, enc0 s4..s0.
    //   enc0: 1,2,3,4,4   enc1: 2,2,2,3,3   enc2: 1,3,3,3,3
    localparam logic [DEF_NUM_ENC*DEF_NUM_SYM*DEF_LEN_W-1:0] DEF_LEN_TABLE = {
        3'd3, 3'd3, 3'd3, 3'd3, 3'd1,
        3'd3, 3'd3, 3'd2, 3'd2, 3'd2,
        3'd4, 3'd4, 3'd3, 3'd2, 3'd1
    };

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EVAL = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/encoder_selector_seq_mac.sv
// enc_len_mac: combinational total codeword length of one encoder row.
//   freq    : NUM_SYM packed symbol frequencies
//   len_row : NUM_SYM packed codeword lengths for one encoder
//   total   : sum over s of freq[s]*len_row[s], full TOT_W precision
module enc_len_mac #(
    parameter int NUM_SYM = 5,
    parameter int FREQ_W  = 10,
    parameter int LEN_W   = 3,
    parameter int TOT_W   = 16
) (
    input  logic [NUM_SYM*FREQ_W-1:0] freq,
    input  logic [NUM_SYM*LEN_W-1:0]  len_row,
    output logic [TOT_W-1:0]          total
);

    always_comb begin
        total = '0;
        for (int s = 0; s < NUM_SYM; s++) begin
            total = total + TOT_W'(freq[s*FREQ_W +: FREQ_W]) * TOT_W'(len_row[s*LEN_W +: LEN_W]);
        end
    end

endmodule

// File: rtl/encoder_selector_seq.sv
// encoder_selector_seq: evaluates one codebook per cycle and reports the
// shortest (or a forced) codebook with its total length.
//   CLK, RST      : clock, async active-low reset
//   start         : request, sampled only in IDLE
//   freq          : per-symbol frequencies, latched with start
//   force_en/sel  : override request, latched with start
//   busy          : high whenever not IDLE
//   done          : one-cycle result-valid pulse
//   encoder_sel   : chosen encoder, held until the next done
//   best_len      : total length of encoder_sel, held until the next done
//
// state   | meaning
// --------+----------------------------------------------------------
// IDLE    | waiting for start
// EVAL    | one encoder per cycle, e = 0 .. NUM_ENC-1
// DONE    | result registered, done pulse high
module encoder_selector_seq
    import encoder_selector_seq_pkg::*;
#(
    parameter int NUM_SYM = DEF_NUM_SYM,
    parameter int NUM_ENC = DEF_NUM_ENC,
    parameter int FREQ_W  = FREQ_BIT,
    parameter int LEN_W   = DEF_LEN_W,
    parameter int ENC_W   = ENCODER_NUM_BIT,
    parameter int TOT_W   = TOTAL_LEN_BIT,
    parameter logic [NUM_ENC*NUM_SYM*LEN_W-1:0] LEN_TABLE = DEF_LEN_TABLE
) (
    input  logic                      CLK,
    input  logic                      RST,
    input  logic                      start,
    input  logic [NUM_SYM*FREQ_W-1:0] freq,
    input  logic                      force_en,
    input  logic [ENC_W-1:0]          force_sel,
    output logic                      busy,
    output logic                      done,
    output logic [ENC_W-1:0]          encoder_sel,
    output logic [TOT_W-1:0]          best_len
);

    localparam int ROW_W = NUM_SYM * LEN_W;

    state_t                    state_q, state_d;
    logic [ENC_W-1:0]          e_q;
    logic [NUM_SYM*FREQ_W-1:0] freq_q;
    logic                      force_en_q;
    logic [ENC_W-1:0]          force_sel_q;
    logic [TOT_W-1:0]          min_q, min_d;
    logic [ENC_W-1:0]          min_idx_q, min_idx_d;
    logic [TOT_W-1:0]          force_len_q, force_len_d;
    logic [ROW_W-1:0]          row;
    logic [TOT_W-1:0]          len_e;
    logic                      last_enc;
    logic                      forced;

    // One MAC, time-shared across encoders by selecting the row for e.
    assign row      = LEN_TABLE[int'(e_q)*ROW_W +: ROW_W];
    assign last_enc = (int'(e_q) == NUM_ENC - 1);
    // An out-of-range forced index falls back to the argmin result.
    assign forced   = force_en_q && (int'(force_sel_q) < NUM_ENC);

    enc_len_mac #(
        .NUM_SYM (NUM_SYM),
        .FREQ_W  (FREQ_W),
        .LEN_W   (LEN_W),
        .TOT_W   (TOT_W)
    ) u_mac (
        .freq    (freq_q),
        .len_row (row),
        .total   (len_e)
    );

    // Strict less-than keeps the lowest index on ties.
    always_comb begin
        min_d       = min_q;
        min_idx_d   = min_idx_q;
        force_len_d = force_len_q;
        if ((e_q == '0) || (len_e < min_q)) begin
            min_d     = len_e;
            min_idx_d = e_q;
        end
        if (e_q == force_sel_q) begin
            force_len_d = len_e;
        end
    end

    always_comb begin
        state_d = state_q;
        busy    = 1'b0;
        case (state_q)
            ST_IDLE: if (start) state_d = ST_EVAL;
            ST_EVAL: begin
                busy = 1'b1;
                if (last_enc) state_d = ST_DONE;
            end
            ST_DONE: begin
                busy    = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) state_q <= ST_IDLE;
        else      state_q <= state_d;
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            e_q         <= '0;
            freq_q      <= '0;
            force_en_q  <= 1'b0;
            force_sel_q <= '0;
            min_q       <= '0;
            min_idx_q   <= '0;
            force_len_q <= '0;
            done        <= 1'b0;
            encoder_sel <= '0;
            best_len    <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        freq_q      <= freq;
                        force_en_q  <= force_en;
                        force_sel_q <= force_sel;
                        e_q         <= '0;
                    end
                end
                ST_EVAL: begin
                    min_q       <= min_d;
                    min_idx_q   <= min_idx_d;
                    force_len_q <= force_len_d;
                    // Results are registered on the edge into DONE so they
                    // are valid for the whole done cycle.
                    if (last_enc) begin
                        done        <= 1'b1;
                        encoder_sel <= forced ? force_sel_q : min_idx_d;
                        best_len    <= forced ? force_len_d : min_d;
                    end else begin
                        e_q <= e_q + ENC_W'(1);
                    end
                end
                default: done <= 1'b0;
            endcase
        end
    end

endmodule

// File: tb/tb_encoder_selector_seq.sv
module tb_encoder_selector_seq;

    localparam int NS = 5;
    localparam int NE = 3;
    localparam int FW = 10;

    logic          CLK;
    logic          RST;
    logic          start;
    logic [NS*FW-1:0] freq;
    logic          force_en;
    logic [1:0]    force_sel;
    logic          busy;
    logic          done;
    logic [1:0]    encoder_sel;
    logic [15:0]   best_len;

    encoder_selector_seq dut (
        .CLK         (CLK),
        .RST         (RST),
        .start       (start),
        .freq        (freq),
        .force_en    (force_en),
        .force_sel   (force_sel),
        .busy        (busy),
        .done        (done),
        .encoder_sel (encoder_sel),
        .best_len    (best_len)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int n_chk  = 0;
    int n_pass = 0;
    int done_cnt = 0;

    // Codebook lengths, row per encoder.
    int lt [NE][NS] = '{'{1,2,3,4,4}, '{2,2,2,3,3}, '{1,3,3,3,3}};

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    endtask

    // Reference: total length of every codebook, strict minimum, optional override.
    task automatic model_eval(input logic [NS*FW-1:0] fv, input logic fe, input int fs,
                              output int sel, output int len);
        int tot [NE];
        for (int e = 0; e < NE; e++) begin
            tot[e] = 0;
            for (int s = 0; s < NS; s++) tot[e] += int'(fv[s*FW +: FW]) * lt[e][s];
        end
        sel = 0;
        for (int e = 1; e < NE; e++) if (tot[e] < tot[sel]) sel = e;
        if (fe && fs < NE) sel = fs;
        len = tot[sel];
    endtask

    // Cycles left in the current request (NE+1 after acceptance, 1 = done cycle).
    int m_cnt = 0;
    int m_sel = 0, m_len = 0;
    int p_sel = 0, p_len = 0;

    always @(posedge CLK or negedge RST) begin
        if (!RST) begin
            m_cnt = 0;
            m_sel = 0;
            m_len = 0;
        end else if (m_cnt == 0) begin
            if (start) begin
                model_eval(freq, force_en, int'(force_sel), p_sel, p_len);
                m_cnt = NE + 1;
            end
        end else begin
            m_cnt--;
            if (m_cnt == 1) begin
                m_sel = p_sel;
                m_len = p_len;
            end
        end
    end

    always @(negedge CLK) begin
        chk("busy", int'(busy), int'(m_cnt > 0));
        chk("done", int'(done), int'(m_cnt == 1));
        chk("encoder_sel", int'(encoder_sel), m_sel);
        chk("best_len", int'(best_len), m_len);
        if (done) done_cnt++;
    end

    function automatic logic [NS*FW-1:0] pack(input int f0, f1, f2, f3, f4);
        logic [NS*FW-1:0] v;
        v = {FW'(f4), FW'(f3), FW'(f2), FW'(f1), FW'(f0)};
        return v;
    endfunction

    task automatic req(input string name, input logic [NS*FW-1:0] fv, input logic fe,
                       input logic [1:0] fs, input int exp_sel, input int exp_len);
        int cyc;
        @(negedge CLK);
        freq = fv; force_en = fe; force_sel = fs; start = 1'b1;
        @(negedge CLK);
        start = 1'b0;
        freq = NS*FW'($urandom);
        force_en = ~fe;
        cyc = 1;
        while (!done && cyc < 12) begin
            @(negedge CLK);
            cyc++;
        end
        chk({name, " latency"}, cyc, NE + 1);
        chk({name, " sel"}, int'(encoder_sel), exp_sel);
        chk({name, " len"}, int'(best_len), exp_len);
        @(negedge CLK);
    endtask

    initial begin
        int d0;
        RST = 1'b0; start = 1'b0; freq = '0; force_en = 1'b0; force_sel = '0;
        repeat (3) @(negedge CLK);
        chk("reset busy", int'(busy), 0);
        chk("reset done", int'(done), 0);
        chk("reset sel", int'(encoder_sel), 0);
        chk("reset len", int'(best_len), 0);
        #2 RST = 1'b1;
        repeat (2) @(negedge CLK);

        req("basic",    pack(10,5,3,1,1), 1'b0, 2'd0, 0, 37);
        req("enc2",     pack(20,0,0,1,1), 1'b0, 2'd0, 2, 26);
        req("tie",      pack(0,0,0,5,5),  1'b0, 2'd0, 1, 30);
        req("force2",   pack(10,5,3,1,1), 1'b1, 2'd2, 2, 40);
        req("force3",   pack(10,5,3,1,1), 1'b1, 2'd3, 0, 37);
        req("force0",   pack(20,0,0,1,1), 1'b1, 2'd0, 0, 28);
        req("maxfreq",  pack(1023,1023,1023,1023,1023), 1'b0, 2'd0, 1, 12276);

        // Starts during EVAL and during the done cycle are ignored.
        d0 = done_cnt;
        @(negedge CLK);
        freq = pack(20,0,0,1,1); force_en = 1'b0; start = 1'b1;
        @(negedge CLK); start = 1'b0;
        @(negedge CLK); start = 1'b1; freq = pack(10,5,3,1,1);
        @(negedge CLK); start = 1'b0;
        @(negedge CLK);
        chk("ign done", int'(done), 1);
        chk("ign len", int'(best_len), 26);
        start = 1'b1;
        @(negedge CLK); start = 1'b0;
        repeat (8) @(negedge CLK);
        chk("ign count", done_cnt - d0, 1);

        // Reset in the middle of an evaluation.
        @(negedge CLK);
        freq = pack(0,0,0,5,5); start = 1'b1;
        @(negedge CLK); start = 1'b0;
        @(negedge CLK);
        #2 RST = 1'b0;
        #1;
        chk("abort busy", int'(busy), 0);
        chk("abort done", int'(done), 0);
        chk("abort sel", int'(encoder_sel), 0);
        chk("abort len", int'(best_len), 0);
        d0 = done_cnt;
        repeat (2) @(negedge CLK);
        #2 RST = 1'b1;
        repeat (6) @(negedge CLK);
        chk("abort no done", done_cnt - d0, 0);

        req("after rst", pack(10,5,3,1,1), 1'b0, 2'd0, 0, 37);
        req("after rst2", pack(0,0,0,5,5), 1'b1, 2'd2, 2, 30);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, passed %0d of %0d", n_pass, n_chk);
        $fatal(1);
    end

endmodule
